divider_seq: RTL and testbench

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq.sv | 135 +++++++++++++
 tb/tb_divider_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per cycle.
// Handles signed (DIV) and unsigned (DIVU) requests, divide-by-zero, and cancel.
module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             sign,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    output logic             out_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);

    // Handshake: the requester holds in_valid (with sign/srca/srcb) high until
    // out_valid. A start is sampled only in IDLE when cancel is low. out_valid
    // is a single-cycle pulse in DONE. Inputs are ignored in BUSY and DONE.
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // dvd_q shifts the dividend out at the top and collects quotient bits at the bottom.
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               qbit;
    logic [WIDTH-1:0]   rem_new;
    logic [WIDTH-1:0]   quo_new;

    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign qbit    = ~diff[WIDTH];
    assign rem_new = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_new = {dvd_q[WIDTH-2:0], qbit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && !cancel) begin
                    dvd_d   = (sign && srca[WIDTH-1]) ? -srca : srca;
                    dvs_d   = (sign && srcb[WIDTH-1]) ? -srcb : srcb;
                    rem_d   = '0;
                    cnt_d   = '0;
                    qneg_d  = sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                    rneg_d  = sign & srca[WIDTH-1];
                    dz_d    = (srcb == '0);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    dvd_d = quo_new;
                    rem_d = rem_new;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // Divide-by-zero: the remainder path already yields the raw
                        // dividend after sign restore; only the quotient is forced.
                        lo_d    = dz_q ? '1 : (qneg_q ? -quo_new : quo_new);
                        hi_d    = rneg_q ? -rem_new : rem_new;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid = (state_q == DONE) && !cancel;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed corner cases, random operands
// against an arithmetic reference model, back-to-back, cancel and async reset.
module tb_divider_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         sign;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         cancel;
  logic         out_valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [W-1:0] last_q, last_r;

  divider_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sign      (sign),
    .srca      (srca),
    .srcb      (srcb),
    .cancel    (cancel),
    .out_valid (out_valid),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: {quotient, remainder} from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, qq, rr;
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[W-1:0];
      r  = rr[W-1:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // driver: called at a negedge; holds in_valid until out_valid, scrambles operands while busy
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output int lat, output bit stable, output bit single);
    logic [W-1:0] h0, l0;
    h0 = hi;
    l0 = lo;
    sign = s;
    srca = a;
    srcb = b;
    in_valid = 1'b1;
    stable = 1'b1;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      srca = $urandom;
      srcb = $urandom;
      sign = 1'($urandom_range(0, 1));
    end
    q = lo;
    r = hi;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    single = !out_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    cancel = 1'b0;
    sign = 1'b0;
    srca = '0;
    srcb = '0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_valid=%b hi=%h lo=%h, required 0/0/0", out_valid, hi, lo);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL reset_release: out_valid=%b hi=%h lo=%h, required 0/0/0", out_valid, hi, lo);
    end
  endtask

  task automatic test_directed;
    logic         s_t[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] a_t[7]  = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd5};
    logic [W-1:0] b_t[7]  = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
    logic [W-1:0] eq_t[7] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] er_t[7] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd5, 32'd5};
    logic [W-1:0] q, r;
    int lat;
    bit stable, single;
    for (int i = 0; i < 7; i++) begin
      do_op(s_t[i], a_t[i], b_t[i], q, r, lat, stable, single);
      n_checks++;
      if (q !== eq_t[i] || r !== er_t[i]) begin
        n_fail++;
        $display("FAIL directed_%0d_result: lo=%h hi=%h, required lo=%h hi=%h", i, q, r, eq_t[i], er_t[i]);
      end
      n_checks++;
      if (lat != W + 1) begin
        n_fail++;
        $display("FAIL directed_%0d_latency: %0d cycles, required %0d", i, lat, W + 1);
      end
      n_checks++;
      if (!single || !stable) begin
        n_fail++;
        $display("FAIL directed_%0d_pulse: single=%0d stable_while_busy=%0d, required 1/1", i, single, stable);
      end
      last_q = q;
      last_r = r;
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, q, r;
    logic s;
    logic [63:0] e;
    int lat;
    bit stable, single;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = W'($urandom_range(1, 15));
        1: b = '0;
        2: b = '1;
        3: begin b = $urandom; a = 32'h8000_0000; end
        default: b = $urandom;
      endcase
      exp_q.push_back(model(s, a, b));
      do_op(s, a, b, q, r, lat, stable, single);
      e = exp_q.pop_front();
      n_checks++;
      if ({q, r} !== e || lat != W + 1 || !single || !stable) begin
        n_fail++;
        $display("FAIL random_%0d (s=%b a=%h b=%h): lo=%h hi=%h lat=%0d single=%0d stable=%0d, required lo=%h hi=%h lat=%0d",
                 i, s, a, b, q, r, lat, single, stable, e[63:32], e[31:0], W + 1);
      end
      last_q = q;
      last_r = r;
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    bit stable;
    sign = 1'b0;
    srca = 32'd100;
    srcb = 32'd7;
    in_valid = 1'b1;
    gap = 0;
    while (gap < 100) begin
      @(posedge clk);
      gap++;
      @(negedge clk);
      if (out_valid) break;
    end
    n_checks++;
    if (!out_valid || lo !== 32'd14 || hi !== 32'd2) begin
      n_fail++;
      $display("FAIL b2b_first: out_valid=%b lo=%h hi=%h, required 1/0000000e/00000002", out_valid, lo, hi);
    end
    // second request presented while the first is in DONE; in_valid never drops
    srca = 32'd9;
    srcb = 32'd3;
    gap = 0;
    stable = 1'b1;
    while (gap < 100) begin
      @(posedge clk);
      gap++;
      @(negedge clk);
      if (out_valid) break;
      if (lo !== 32'd14 || hi !== 32'd2) stable = 1'b0;
    end
    in_valid = 1'b0;
    n_checks++;
    if (gap != W + 2) begin
      n_fail++;
      $display("FAIL b2b_gap: pulses %0d cycles apart, required %0d", gap, W + 2);
    end
    n_checks++;
    if (lo !== 32'd3 || hi !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_second: lo=%h hi=%h, required 00000003/00000000", lo, hi);
    end
    n_checks++;
    if (!stable) begin
      n_fail++;
      $display("FAIL b2b_hold: hi/lo changed between pulses, required stable 0000000e/00000002");
    end
    last_q = lo;
    last_r = hi;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_cancel;
    bit pulsed;
    logic [W-1:0] q, r;
    int lat;
    bit stable, single;
    sign = 1'b0;
    srca = 32'd100;
    srcb = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);  // capture
    repeat (10) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (out_valid) pulsed = 1'b1;
    end
    n_checks++;
    if (pulsed) begin
      n_fail++;
      $display("FAIL cancel_no_pulse: out_valid seen after cancel, required none");
    end
    n_checks++;
    if (lo !== last_q || hi !== last_r) begin
      n_fail++;
      $display("FAIL cancel_hold: lo=%h hi=%h, required %h/%h", lo, hi, last_q, last_r);
    end
    // cancel in IDLE blocks a start
    cancel = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    cancel = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (out_valid) pulsed = 1'b1;
    end
    n_checks++;
    if (pulsed) begin
      n_fail++;
      $display("FAIL cancel_idle_block: operation started while cancel held, required none");
    end
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, q, r, lat, stable, single);
    n_checks++;
    if (q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE || lat != W + 1) begin
      n_fail++;
      $display("FAIL cancel_next_op: lo=%h hi=%h lat=%0d, required fffffff2/fffffffe lat=%0d", q, r, lat, W + 1);
    end
    last_q = q;
    last_r = r;
  endtask

  task automatic test_reset_mid_busy;
    bit pulsed;
    logic [W-1:0] q, r;
    int lat;
    bit stable, single;
    sign = 1'b0;
    srca = 32'd100;
    srcb = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL reset_async: out_valid=%b hi=%h lo=%h, required 0/0/0", out_valid, hi, lo);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (out_valid) pulsed = 1'b1;
    end
    n_checks++;
    if (pulsed) begin
      n_fail++;
      $display("FAIL reset_discard: out_valid seen after reset, required none");
    end
    do_op(1'b0, 32'd100, 32'd7, q, r, lat, stable, single);
    n_checks++;
    if (q !== 32'd14 || r !== 32'd2 || lat != W + 1 || !single) begin
      n_fail++;
      $display("FAIL reset_fresh_op: lo=%h hi=%h lat=%0d single=%0d, required 0000000e/00000002 lat=%0d single=1",
               q, r, lat, single, W + 1);
    end
  endtask

  initial begin
    last_q = '0;
    last_r = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_cancel();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
